// File: rtl/icache_fetch.sv
// icache_fetch: 1/2-way set-associative instruction fetch cache.
// Combinational hit path; word-serial line refill on a miss.
module icache_fetch #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              flush_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [31:0]       inst_o,
    output logic              if_stall,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_done_i,
    input  logic [31:0]       mem_data_i
);
    localparam int W     = $clog2(LINE_WORDS);
    localparam int S     = $clog2(SETS);
    localparam int TAG_W = ADDR_W - 2 - W - S;
    localparam int CW    = (W > 0) ? W : 1;
    localparam logic [CW-1:0]     LAST = CW'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LMSK = ADDR_W'(LINE_WORDS * 4 - 1);

    typedef enum logic {IDLE, FILL} state_t;
    state_t r_state;
    state_t w_state_nx;

    logic [31:0]      r_data [2][SETS][LINE_WORDS];
    logic [TAG_W-1:0] r_tag  [2][SETS];
    logic [1:0]       r_valid [SETS];
    logic [SETS-1:0]  r_lru;

    logic [ADDR_W-1:0] r_base;
    logic [S-1:0]      r_set;
    logic [TAG_W-1:0]  r_ltag;
    logic              r_victim;
    logic [CW-1:0]     r_cnt;
    logic              r_req;
    logic [ADDR_W-1:0] r_addr;

    logic [CW-1:0]     w_word;
    logic [S-1:0]      w_set;
    logic [TAG_W-1:0]  w_tag;
    logic [ADDR_W-1:0] w_base;
    logic              w_hit0;
    logic              w_hit1;
    logic              w_hit;
    logic              w_hway;
    logic [31:0]       w_rdata;
    logic              w_victim;
    logic              w_start;
    logic              w_wr;
    logic              w_commit;

    if (W > 0) begin : g_word
        assign w_word = pc_i[W+1:2];
    end else begin : g_word1
        assign w_word = '0;
    end

    assign w_set  = pc_i[W+S+1:W+2];
    assign w_tag  = pc_i[ADDR_W-1:W+S+2];
    assign w_base = pc_i & ~LMSK;

    assign w_hit0 = r_valid[w_set][0]
                 && (r_tag[0][w_set] == w_tag);
    assign w_hit1 = (WAYS == 2) && r_valid[w_set][1]
                 && (r_tag[1][w_set] == w_tag);
    assign w_hit   = w_hit0 | w_hit1;
    assign w_hway  = !w_hit0;
    assign w_rdata = r_data[w_hway][w_set][w_word];

    // Invalid ways are preferred; otherwise the LRU pointer names the victim
    always_comb begin
        w_victim = 1'b0;
        if (WAYS == 2) begin
            if (!r_valid[w_set][0])      w_victim = 1'b0;
            else if (!r_valid[w_set][1]) w_victim = 1'b1;
            else                         w_victim = r_lru[w_set];
        end
    end

    assign mem_req_o  = r_req;
    assign mem_addr_o = r_addr;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        pc_o       = '0;
        inst_o     = '0;
        if_stall   = 1'b0;
        w_start    = 1'b0;
        w_wr       = 1'b0;
        w_commit   = 1'b0;
        if (rst) begin
            w_state_nx = IDLE;
        end else if (flush_i) begin
            if_stall   = 1'b1;
            w_state_nx = IDLE;
        end else begin
            if (w_hit) begin
                pc_o   = pc_i;
                inst_o = w_rdata;
            end else begin
                if_stall = 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (!w_hit) begin
                        w_start    = 1'b1;
                        w_state_nx = FILL;
                    end
                end
                FILL: begin
                    if (mem_done_i) begin
                        w_wr = 1'b1;
                        if (r_cnt == LAST) begin
                            w_commit   = 1'b1;
                            w_state_nx = IDLE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_req    <= 1'b0;
            r_addr   <= '0;
            r_base   <= '0;
            r_set    <= '0;
            r_ltag   <= '0;
            r_victim <= 1'b0;
            r_lru    <= '0;
            for (int i = 0; i < SETS; i++) r_valid[i] <= '0;
        end else if (flush_i) begin
            r_req <= 1'b0;
            r_lru <= '0;
            for (int i = 0; i < SETS; i++) r_valid[i] <= '0;
        end else begin
            if (w_hit && WAYS == 2) r_lru[w_set] <= !w_hway;
            if (w_start) begin
                r_base   <= w_base;
                r_set    <= w_set;
                r_ltag   <= w_tag;
                r_victim <= w_victim;
                r_cnt    <= '0;
                r_req    <= 1'b1;
                r_addr   <= w_base;
                r_valid[w_set][w_victim] <= 1'b0;
            end
            if (w_wr && !w_commit) begin
                r_cnt  <= r_cnt + 1'b1;
                r_addr <= r_base
                        + ((ADDR_W'(r_cnt) + ADDR_W'(1)) << 2);
            end
            // Fill commit wins over a same-edge hit to this set
            if (w_commit) begin
                r_valid[r_set][r_victim] <= 1'b1;
                if (WAYS == 2) r_lru[r_set] <= !r_victim;
                r_req <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_data[r_victim][r_set][r_cnt] <= mem_data_i;
        if (w_commit) r_tag[r_victim][r_set] <= r_ltag;
    end

endmodule

// File: doc/icache_fetch.md
# icache_fetch

Parametrised instruction-fetch cache: the successor to the single-word direct-mapped fetch stage. Supports multi-word lines, 1- or 2-way set associativity with per-set LRU, explicit valid bits and a synchronous flush. It serves `pc_i` combinationally on a hit. On a miss it stalls the pipeline and refills the whole line through a word-serial request/done handshake to the memory controller. It sits between the PC register and the IF/ID latch.

## Interface
- `ADDR_W`, 32: address width.
- `SETS`, 64: number of sets; power of 2, at least 2.
- `LINE_WORDS`, 4: 32-bit words per line; power of 2, at least 1.
- `WAYS`, 2: associativity; 1 or 2 only.
- Derived widths:
  - `W` = log2(`LINE_WORDS`).
  - `S` = log2(`SETS`).
  - `TAG_W` = `ADDR_W`-2-`W`-`S`; must be at least 1.
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `pc_i`  in  `ADDR_W`  fetch address; bits [1:0] ignored.
- `flush_i`  in  1  invalidate the whole cache.
- `pc_o`  out  `ADDR_W`  `pc_i` on hit, else 0.
- `inst_o`  out  32  hit word, else 0.
- `if_stall`  out  1  high when the fetch cannot be served this cycle.
- `mem_req_o`  out  1  refill word request, registered.
- `mem_addr_o`  out  `ADDR_W`  word address of the request, registered, word-aligned.
- `mem_done_i`  in  1  one-cycle pulse: `mem_data_i` is valid for the current `mem_addr_o`.
- `mem_data_i`  in  32  refill data.

## Operation
- Address split:
  - word select = `pc_i`[`W`+1:2].
  - set = `pc_i`[`W`+`S`+1:`W`+2].
  - tag = `pc_i`[`ADDR_W`-1:`W`+`S`+2].
- Storage:
  - data array [`WAYS`][`SETS`][`LINE_WORDS`]x32.
  - tag array [`WAYS`][`SETS`]x`TAG_W`.
  - valid [`WAYS`][`SETS`].
  - lru [`SETS`].
- Lookup (combinational): hit = any way with valid=1 and tag equal.
  - If `rst`: `pc_o`=0, `inst_o`=0, `if_stall`=0.
  - Else if `flush_i`: treated as a miss; `if_stall`=1.
  - Else if hit: `pc_o`=`pc_i`, `inst_o`=selected word, `if_stall`=0.
  - Else: `pc_o`=0, `inst_o`=0, `if_stall`=1.
- LRU (`WAYS`=2):
  - On a hit cycle, lru[set] is set to point at the way not hit.
  - On fill commit, lru[set] is set to point at the way not filled.
  - `WAYS`=1: victim is always way 0; lru is unused.
- Victim selection, latched at miss detection:
  - First invalid way, lowest index first.
  - Otherwise the way pointed to by lru[set].
- FSM states IDLE and FILL. Counter `cnt` is `W` bits wide.
  - IDLE, miss, no `flush_i`, not `rst`:
    - latch base = `pc_i` with bits [`W`+1:0] cleared;
    - latch set, tag and victim;
    - `cnt`<=0, `mem_req_o`<=1, `mem_addr_o`<=base;
    - go to FILL.
  - FILL, on `mem_done_i`:
    - write `mem_data_i` to data[victim][set][`cnt`].
    - If `cnt` != `LINE_WORDS`-1: `cnt`++, `mem_addr_o`<=base+4*(`cnt`+1), `mem_req_o` stays 1.
    - If `cnt` = `LINE_WORDS`-1: write tag, set valid[victim][set]=1, update lru, `mem_req_o`<=0, go to IDLE.
  - valid[victim][set] is cleared on FILL entry. A partially filled line never hits.
  - A `pc_i` change during FILL does not abort the fill. The stall persists while `pc_i` misses. A new miss is serviced only after returning to IDLE.
  - Hits to other sets or ways during FILL are served normally with `if_stall`=0.
- `flush_i` (any state):
  - next edge clears every valid bit and all lru bits;
  - FILL aborts to IDLE and `mem_req_o`<=0.
  - `flush_i` has priority over fill commit on the same edge: the line is not validated.
- `mem_done_i` in IDLE is ignored; no array write.
- Reset mid-fill behaves like flush.
- Reset values:
  - state IDLE, `cnt`=0;
  - `mem_req_o`=0, `mem_addr_o`=0;
  - all valid=0, all lru=0.
  - Data and tag arrays are not reset.

## Timing
- Hit: zero-cycle; output is valid in the same cycle `pc_i` is presented.
- Miss at cycle N: `mem_req_o` rises at N+1 with `mem_addr_o`=base.
- Each `mem_done_i` pulse at cycle M advances `mem_addr_o` at M+1.
- `mem_req_o` stays continuously high across words. The controller treats each address change as a new request.
- Last `mem_done_i` at cycle L: valid visible at L+1, where `if_stall` falls if `pc_i` is still in that line; `mem_req_o` is low at L+1.
- The earliest next-miss request is L+2.
- Miss penalty = latch cycle + sum of memory latencies + 1 commit cycle.

## Test plan
- Reset, `pc_i`=0x0, `LINE_WORDS`=4, done one cycle after each address:
  - `mem_addr_o` sequence 0x0, 0x4, 0x8, 0xC;
  - `if_stall`=1 until the cycle after the 4th done, then `inst_o`=word0, `pc_o`=0x0.
- After that fill, `pc_i`=0x4, 0x8, 0xC: `if_stall`=0 with the correct words and `mem_req_o` held at 0.
- `WAYS`=2, `SETS`=64, set stride 0x400:
  - fill 0x0 (way0), fill 0x400 (way1), hit 0x0, then miss 0x800;
  - 0x800 evicts 0x400 (way1); 0x0 still hits; 0x400 misses.
- Flush after the 2nd done of a fill:
  - `mem_req_o`=0 next cycle;
  - a late `mem_done_i` causes no array write;
  - 0x0 misses and refills starting at 0x0.
- `WAYS`=1: alternating 0x0 / 0x400 misses every time; each fill replaces the other.
- During a fill of 0x0, `pc_i` switches to a resident line 0x1000: hit with `if_stall`=0, and the fill completes normally.
